// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU control path.
//   issue_state_t : issue FSM states (run / serializing op in flight / flush bubble)
//   stall_cause_t : reason the decoded instruction is not issuing this cycle
//   REG_IDX_W     : width of an architectural register index
package cpu_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    IS_RUN    = 2'd0,
    IS_SERIAL = 2'd1,
    IS_FLUSH  = 2'd2
  } issue_state_t;

  typedef enum logic [2:0] {
    SC_NONE   = 3'd0,
    SC_RAW    = 3'd1,
    SC_WAW    = 3'd2,
    SC_FULL   = 3'd3,
    SC_SERIAL = 3'd4,
    SC_FLUSH  = 3'd5,
    SC_DOWN   = 3'd6
  } stall_cause_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one pending bit per architectural register.
//   clk, rst_n           : clock, asynchronous active-low reset
//   set_en / set_idx     : mark a register as having a write in flight
//   clr_en / clr_idx     : clear the mark when the writer retires
//   flush                : clear every mark (wins over set and clear)
//   rs1_idx / rs1_pend   : read port for source 1
//   rs2_idx / rs2_pend   : read port for source 2
//   rd_idx  / rd_pend    : lookup for the destination (WAW check)
//   pending              : all pending bits; bit 0 is hard-wired to 0
module reg_scoreboard
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic                 flush,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic                 rs1_pend,
  output logic                 rs2_pend,
  output logic                 rd_pend,
  output logic [NUM_REGS-1:0]  pending
);

  logic [NUM_REGS-1:0] pending_q;

  // x0 is never tracked
  assign pending_q[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
      // Set and clear never target the same bit in one cycle (WAW blocks it),
      // so their relative priority is irrelevant.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pending_q[gi] <= 1'b0;
        end else if (flush) begin
          pending_q[gi] <= 1'b0;
        end else if (set_en && (set_idx == REG_IDX_W'(gi))) begin
          pending_q[gi] <= 1'b1;
        end else if (clr_en && (clr_idx == REG_IDX_W'(gi))) begin
          pending_q[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign rs1_pend = pending_q[rs1_idx];
  assign rs2_pend = pending_q[rs2_idx];
  assign rd_pend  = pending_q[rd_idx];
  assign pending  = pending_q;

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller between decode and execute.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   dec_valid / dec_ready         : decoded instruction handshake (dec_ready = accepted)
//   dec_rd, dec_rd_en             : destination register and its write enable
//   dec_rs1/dec_r1_en, dec_rs2/dec_r2_en : source registers and read enables
//   dec_csrr_en, dec_serial       : serializing instruction classes
//   iss_valid / iss_ready         : zero-latency pass-through to execute
//   ret_valid, ret_rd_en, ret_rd  : one retirement per cycle
//   flush                         : kill everything in flight
//   pending                       : scoreboard bits
//   stall_cause                   : stall_cause_t of the presented instruction
//   protocol_err                  : sticky, retire seen with nothing in flight
module issue_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [REG_IDX_W-1:0] dec_rd,
  input  logic                 dec_rd_en,
  input  logic [REG_IDX_W-1:0] dec_rs1,
  input  logic                 dec_r1_en,
  input  logic [REG_IDX_W-1:0] dec_rs2,
  input  logic                 dec_r2_en,
  input  logic                 dec_csrr_en,
  input  logic                 dec_serial,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  input  logic                 ret_valid,
  input  logic                 ret_rd_en,
  input  logic [REG_IDX_W-1:0] ret_rd,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  pending,
  output logic [2:0]           stall_cause,
  output logic                 protocol_err
);

  issue_state_t     state_q, state_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             perr_q, perr_d;

  logic rs1_pend, rs2_pend, rd_pend;
  logic raw, waw, full, ser_op, ser_block, go, fire;
  logic ret_ok, ret_at_zero, sb_set, sb_clr;
  stall_cause_t cause;

  // Hazard terms use registered state only: a retire in this cycle does not
  // unblock a reader until the next cycle.
  assign raw = (dec_r1_en && (dec_rs1 != '0) && rs1_pend) ||
               (dec_r2_en && (dec_rs2 != '0) && rs2_pend);
  assign waw = dec_rd_en && (dec_rd != '0) && rd_pend;
  assign full      = (inflight_q == CNT_W'(MAX_INFLIGHT));
  assign ser_op    = dec_csrr_en || dec_serial;
  assign ser_block = ser_op && (inflight_q != '0);

  assign go        = (state_q == IS_RUN) && !flush && !raw && !waw && !full && !ser_block;
  assign iss_valid = dec_valid && go;
  assign dec_ready = go && iss_ready;
  assign fire      = dec_valid && dec_ready;

  // A retire with nothing in flight is a protocol violation: counted as an
  // error and otherwise ignored by the counter. Flush discards retires.
  assign ret_ok      = ret_valid && !flush && (inflight_q != '0);
  assign ret_at_zero = ret_valid && !flush && (inflight_q == '0);

  assign sb_set = fire && dec_rd_en && (dec_rd != '0);
  assign sb_clr = ret_valid && ret_rd_en && (ret_rd != '0);

  reg_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (sb_set),
    .set_idx  (dec_rd),
    .clr_en   (sb_clr),
    .clr_idx  (ret_rd),
    .flush    (flush),
    .rs1_idx  (dec_rs1),
    .rs2_idx  (dec_rs2),
    .rd_idx   (dec_rd),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend),
    .pending  (pending)
  );

  // In-flight counter and sticky error
  always_comb begin
    inflight_d = inflight_q;
    perr_d     = perr_q || ret_at_zero;
    if (flush) begin
      inflight_d = '0;
    end else if (fire && !ret_ok) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!fire && ret_ok) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  // Issue FSM next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IS_FLUSH;
    end else begin
      unique case (state_q)
        IS_RUN:    if (fire && ser_op) state_d = IS_SERIAL;
        IS_SERIAL: if (inflight_d == '0) state_d = IS_RUN;
        IS_FLUSH:  state_d = IS_RUN;
        default:   state_d = IS_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IS_FLUSH;
      inflight_q <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      perr_q     <= perr_d;
    end
  end

  // Stall reason, prioritised; only meaningful while an instruction is offered
  always_comb begin
    cause = SC_NONE;
    if (dec_valid) begin
      if (flush || (state_q == IS_FLUSH))              cause = SC_FLUSH;
      else if ((state_q == IS_SERIAL) || ser_block)    cause = SC_SERIAL;
      else if (raw)                                    cause = SC_RAW;
      else if (waw)                                    cause = SC_WAW;
      else if (full)                                   cause = SC_FULL;
      else if (!iss_ready)                             cause = SC_DOWN;
      else                                             cause = SC_NONE;
    end
  end

  assign stall_cause  = cause;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, dec_ready, dec_rd_en, dec_r1_en, dec_r2_en;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2, ret_rd;
  logic        dec_csrr_en, dec_serial, iss_valid, iss_ready;
  logic        ret_valid, ret_rd_en, flush, protocol_err;
  logic [31:0] pending;
  logic [2:0]  stall_cause;

  always #5 clk = ~clk;

  issue_ctrl #(.NUM_REGS(32), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rd(dec_rd), .dec_rd_en(dec_rd_en),
    .dec_rs1(dec_rs1), .dec_r1_en(dec_r1_en),
    .dec_rs2(dec_rs2), .dec_r2_en(dec_r2_en),
    .dec_csrr_en(dec_csrr_en), .dec_serial(dec_serial),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .ret_valid(ret_valid), .ret_rd_en(ret_rd_en), .ret_rd(ret_rd),
    .flush(flush), .pending(pending),
    .stall_cause(stall_cause), .protocol_err(protocol_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks: set of registers with an outstanding writer, number of
  // outstanding instructions, whether a serializing op is outstanding, whether
  // this cycle is the bubble following a flush/reset, and the sticky error.
  localparam int MAXF = 4;
  logic [31:0] m_pend;
  int          m_cnt;
  bit          m_bubble, m_serial, m_perr;
  bit          last_fire, last_ret, last_flush;
  bit          e_raw, e_waw, e_ser, e_go, e_iss, e_rdy;
  logic [2:0]  e_sc;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pend = '0; m_cnt = 0; m_bubble = 1; m_serial = 0; m_perr = 0;
    end
    e_raw = (dec_r1_en && dec_rs1 != 0 && m_pend[dec_rs1]) ||
            (dec_r2_en && dec_rs2 != 0 && m_pend[dec_rs2]);
    e_waw = dec_rd_en && dec_rd != 0 && m_pend[dec_rd];
    e_ser = dec_csrr_en || dec_serial;
    e_go  = !m_bubble && !m_serial && !flush && !e_raw && !e_waw &&
            (m_cnt < MAXF) && !(e_ser && m_cnt > 0);
    e_iss = dec_valid && e_go;
    e_rdy = e_go && iss_ready;
    if (!dec_valid)                        e_sc = SC_NONE;
    else if (flush || m_bubble)            e_sc = SC_FLUSH;
    else if (m_serial || (e_ser && m_cnt > 0)) e_sc = SC_SERIAL;
    else if (e_raw)                        e_sc = SC_RAW;
    else if (e_waw)                        e_sc = SC_WAW;
    else if (m_cnt >= MAXF)                e_sc = SC_FULL;
    else if (!iss_ready)                   e_sc = SC_DOWN;
    else                                   e_sc = SC_NONE;

    check("dec_ready",    32'(dec_ready),    32'(e_rdy));
    check("iss_valid",    32'(iss_valid),    32'(e_iss));
    check("stall_cause",  32'(stall_cause),  32'(e_sc));
    check("pending",      pending,           m_pend);
    check("protocol_err", 32'(protocol_err), 32'(m_perr));

    last_fire  = rst_n && dec_valid && e_rdy;
    last_ret   = rst_n && ret_valid && !flush;
    last_flush = rst_n && flush;

    if (rst_n) begin
      if (flush) begin
        m_pend = '0; m_cnt = 0; m_bubble = 1; m_serial = 0;
      end else begin
        m_bubble = 0;
        if (ret_valid) begin
          if (m_cnt == 0) m_perr = 1;
          else m_cnt--;
          if (ret_rd_en && ret_rd != 0) m_pend[ret_rd] = 1'b0;
        end
        if (last_fire) begin
          if (dec_rd_en && dec_rd != 0) m_pend[dec_rd] = 1'b1;
          m_cnt++;
          if (e_ser) m_serial = 1;
        end
        if (m_serial && m_cnt == 0) m_serial = 0;
      end
    end
  end

  // ---------------- in-flight tracking for legal retires ----------------
  typedef struct packed { logic en; logic [4:0] rd; } ent_t;
  ent_t q[$];

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n || last_flush) q.delete();
    else begin
      if (last_ret && q.size() > 0) q.delete(0);
      if (last_fire) q.push_back(ent_t'({dec_rd_en, dec_rd}));
    end
  endtask

  task automatic present(input logic [4:0] rd, input logic rd_en, input logic [4:0] rs1,
                         input logic r1, input logic [4:0] rs2, input logic r2, input logic csr);
    dec_valid = 1; dec_rd = rd; dec_rd_en = rd_en; dec_rs1 = rs1; dec_r1_en = r1;
    dec_rs2 = rs2; dec_r2_en = r2; dec_csrr_en = csr; dec_serial = 0;
  endtask

  task automatic drain();
    dec_valid = 0; flush = 0;
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      ret_valid = 1; ret_rd_en = q[0].en; ret_rd = q[0].rd;
      step();
    end
    ret_valid = 0;
  endtask

  initial begin
    rst_n = 0; dec_valid = 0; dec_rd = 0; dec_rd_en = 0; dec_rs1 = 0; dec_r1_en = 0;
    dec_rs2 = 0; dec_r2_en = 0; dec_csrr_en = 0; dec_serial = 0; iss_ready = 1;
    ret_valid = 0; ret_rd_en = 0; ret_rd = 0; flush = 0;
    step(); step();
    @(negedge clk);
    check("rst_pending", pending, 32'h0);
    check("rst_ready", 32'(dec_ready), 32'h0);
    check("rst_perr", 32'(protocol_err), 32'h0);

    // RAW on x5, no bypass
    step(); rst_n = 1; present(5, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_bubble", 32'(stall_cause), 32'(SC_FLUSH));
    step(); @(negedge clk);
    check("addi_ready", 32'(dec_ready), 32'h1);
    step(); present(6, 1, 5, 1, 1, 1, 0);
    @(negedge clk);
    check("add_raw", 32'(stall_cause), 32'(SC_RAW));
    check("x5_pending", 32'(pending[5]), 32'h1);
    step(); ret_valid = 1; ret_rd_en = 1; ret_rd = 5;
    @(negedge clk);
    check("no_bypass", 32'(dec_ready), 32'h0);
    step(); ret_valid = 0;
    @(negedge clk);
    check("add_issues", 32'(dec_ready), 32'h1);
    step(); dec_valid = 0;
    @(negedge clk);
    check("x6_pending", pending, 32'h40);

    // drain, then a bogus retire with nothing in flight
    drain();
    ret_valid = 1; ret_rd_en = 0;
    step(); ret_valid = 0;
    @(negedge clk);
    check("perr_set", 32'(protocol_err), 32'h1);

    // rd = x0 never marks pending
    step(); present(0, 1, 0, 0, 0, 0, 0);
    step(); dec_valid = 0;
    @(negedge clk);
    check("x0_untracked", pending, 32'h0);
    drain();

    // fill the window with x1..x4, fifth stalls on FULL
    for (int i = 1; i <= 4; i++) begin
      present(5'(i), 1, 0, 0, 0, 0, 0);
      step();
    end
    present(7, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("full_stall", 32'(stall_cause), 32'(SC_FULL));
    step(); ret_valid = 1; ret_rd_en = 1; ret_rd = 1;
    @(negedge clk);
    check("full_ret_cycle", 32'(dec_ready), 32'h0);
    step(); ret_rd = 2;
    @(negedge clk);
    check("issue_with_ret", 32'(dec_ready), 32'h1);
    step(); ret_valid = 0; dec_valid = 0;
    drain();

    // CSR (writes x9) enters SERIAL, then reset mid-SERIAL
    present(9, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("csr_ready", 32'(dec_ready), 32'h1);
    step(); present(10, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("serial_stall", 32'(stall_cause), 32'(SC_SERIAL));
    check("x9_pending", 32'(pending[9]), 32'h1);
    step(); rst_n = 0;
    #1;
    check("async_pending", pending, 32'h0);
    check("async_ready", 32'(dec_ready), 32'h0);
    step(); rst_n = 1;
    @(negedge clk);
    check("release_bubble", 32'(dec_ready), 32'h0);
    step(); @(negedge clk);
    check("release_issue", 32'(dec_ready), 32'h1);
    step(); dec_valid = 0;
    drain();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (!dec_valid || last_fire || last_flush) begin
        dec_valid   = ($urandom_range(0, 3) != 0);
        dec_rd      = 5'($urandom_range(0, 7));
        dec_rd_en   = 1'($urandom_range(0, 1));
        dec_rs1     = 5'($urandom_range(0, 7));
        dec_r1_en   = 1'($urandom_range(0, 1));
        dec_rs2     = 5'($urandom_range(0, 7));
        dec_r2_en   = 1'($urandom_range(0, 1));
        dec_csrr_en = ($urandom_range(0, 15) == 0);
        dec_serial  = ($urandom_range(0, 15) == 0);
      end
      iss_ready = ($urandom_range(0, 4) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        ret_valid = 1; ret_rd_en = q[0].en; ret_rd = q[0].rd;
      end else begin
        ret_valid = 0; ret_rd_en = 1'($urandom_range(0, 1)); ret_rd = 5'($urandom_range(0, 31));
      end
      step();
    end
    iss_ready = 1;
    drain();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
